// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, control-word layout and the ID/EX stage FSM state type.
package cpu_pkg;

  localparam int unsigned CW_W = 7;
  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_BE  = 4'b0100;
  localparam logic [OP_W-1:0] OP_LDR = 4'b1001;
  localparam logic [OP_W-1:0] OP_STR = 4'b1010;

  localparam int unsigned CW_WRE     = 6;
  localparam int unsigned CW_WME     = 5;
  localparam int unsigned CW_WB      = 4;
  localparam int unsigned CW_ALU_MSB = 3;
  localparam int unsigned CW_ALU_LSB = 0;

  typedef logic [CW_W-1:0] ctrl_word_t;

  localparam ctrl_word_t CW_BUBBLE = 7'b0;

  typedef enum logic {
    ST_RUN,
    ST_STALL
  } id_ex_state_t;

  // Which register sources an opcode reads: bit 0 = rs1, bit 1 = rs2.
  function automatic logic [1:0] src_usage(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_STR, OP_BE: src_usage = 2'b11;
      OP_LDR:                src_usage = 2'b01;
      default:               src_usage = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: flags an ID instruction that reads the
// destination of a write-enabled load currently sitting in EX.
module hazard_detect
  import cpu_pkg::*;
#(
  parameter int unsigned REG_AW = 4
) (
  input  logic [OP_W-1:0]   opcode,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [OP_W-1:0]   ex_opcode,
  input  logic              ex_wre,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              hazard_c
);

  logic [1:0] uses;

  always_comb begin
    uses     = src_usage(opcode);
    hazard_c = (ex_opcode == OP_LDR) && ex_wre &&
               ((uses[0] && (rs1 == ex_rd)) || (uses[1] && (rs2 == ex_rd)));
  end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall and branch-flush bubble insertion,
// plus a saturating count of inserted bubbles.
module id_ex_hazard_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W            = 32,
  parameter int unsigned REG_AW            = 4,
  parameter int unsigned LOAD_STALL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW_W-1:0]   control_signals_i,
  input  logic [OP_W-1:0]   opcode_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              branch_taken_i,
  output logic [CW_W-1:0]   ex_control_o,
  output logic [OP_W-1:0]   ex_opcode_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [DATA_W-1:0] ex_rs1_data_o,
  output logic [DATA_W-1:0] ex_rs2_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic              stall_o,
  output logic              flush_o,
  output logic [15:0]       bubble_count_o
);

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned BCNT_W  = 16;
  localparam logic [BCNT_W-1:0] BCNT_MAX = '1;

  id_ex_state_t     state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             hazard;
  logic             load_bubble;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .opcode    (opcode_i),
    .rs1       (rs1_i),
    .rs2       (rs2_i),
    .ex_opcode (ex_opcode_o),
    .ex_wre    (ex_control_o[CW_WRE]),
    .ex_rd     (ex_rd_o),
    .hazard_c  (hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Branch flush beats load-use stall; a flush also cancels any remaining stall.
  always_comb begin
    next_state  = state;
    next_cnt    = cnt;
    stall_o     = 1'b0;
    flush_o     = 1'b0;
    load_bubble = 1'b0;
    case (state)
      ST_RUN: begin
        if (branch_taken_i) begin
          flush_o     = 1'b1;
          load_bubble = 1'b1;
        end else if (hazard) begin
          stall_o     = 1'b1;
          load_bubble = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            next_state = ST_STALL;
            next_cnt   = CNT_W'(LOAD_STALL_CYCLES - 1);
          end
        end
      end
      ST_STALL: begin
        load_bubble = 1'b1;
        if (branch_taken_i) begin
          flush_o    = 1'b1;
          next_cnt   = '0;
          next_state = ST_RUN;
        end else begin
          stall_o  = 1'b1;
          next_cnt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) next_state = ST_RUN;
        end
      end
      default: next_state = ST_RUN;
    endcase
  end

  // Bubbles clear data fields as well as control so EX sees a clean nop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_control_o  <= CW_BUBBLE;
      ex_opcode_o   <= OP_NOP;
      ex_rd_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
    end else if (load_bubble) begin
      ex_control_o  <= CW_BUBBLE;
      ex_opcode_o   <= OP_NOP;
      ex_rd_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
    end else begin
      ex_control_o  <= control_signals_i;
      ex_opcode_o   <= opcode_i;
      ex_rd_o       <= rd_i;
      ex_rs1_data_o <= rs1_data_i;
      ex_rs2_data_o <= rs2_data_i;
      ex_imm_o      <= imm_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count_o <= '0;
    end else if (load_bubble && (bubble_count_o != BCNT_MAX)) begin
      bubble_count_o <= bubble_count_o + BCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage: two instances (1 and 3 stall cycles) driven in
// lockstep and compared against a rule-level pipeline model.
module tb_id_ex_hazard_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned RW = 7 + 4 + AW + 3 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    ctrl;
  logic [3:0]    op;
  logic [AW-1:0] rs1, rs2, rd;
  logic [DW-1:0] d1, d2, imm;
  logic          br;

  logic [6:0]    ex_ctrl [2];
  logic [3:0]    ex_op   [2];
  logic [AW-1:0] ex_rd   [2];
  logic [DW-1:0] ex_d1   [2];
  logic [DW-1:0] ex_d2   [2];
  logic [DW-1:0] ex_imm  [2];
  logic          stall   [2];
  logic          flush   [2];
  logic [15:0]   bcnt    [2];

  // Reference model: EX contents, bubbles still owed, bubble total.
  logic [6:0]    m_ctrl [2];
  logic [3:0]    m_op   [2];
  logic [AW-1:0] m_rd   [2];
  logic [DW-1:0] m_d1   [2];
  logic [DW-1:0] m_d2   [2];
  logic [DW-1:0] m_imm  [2];
  int            m_rem  [2];
  int            m_cnt  [2];
  int            lsc    [2] = '{1, 3};

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  id_ex_hazard_stage #(.DATA_W(DW), .REG_AW(AW), .LOAD_STALL_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .control_signals_i(ctrl), .opcode_i(op),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .rs1_data_i(d1), .rs2_data_i(d2),
    .imm_i(imm), .branch_taken_i(br),
    .ex_control_o(ex_ctrl[0]), .ex_opcode_o(ex_op[0]), .ex_rd_o(ex_rd[0]),
    .ex_rs1_data_o(ex_d1[0]), .ex_rs2_data_o(ex_d2[0]), .ex_imm_o(ex_imm[0]),
    .stall_o(stall[0]), .flush_o(flush[0]), .bubble_count_o(bcnt[0])
  );

  id_ex_hazard_stage #(.DATA_W(DW), .REG_AW(AW), .LOAD_STALL_CYCLES(3)) u_b (
    .clk(clk), .rst(rst), .control_signals_i(ctrl), .opcode_i(op),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .rs1_data_i(d1), .rs2_data_i(d2),
    .imm_i(imm), .branch_taken_i(br),
    .ex_control_o(ex_ctrl[1]), .ex_opcode_o(ex_op[1]), .ex_rd_o(ex_rd[1]),
    .ex_rs1_data_o(ex_d1[1]), .ex_rs2_data_o(ex_d2[1]), .ex_imm_o(ex_imm[1]),
    .stall_o(stall[1]), .flush_o(flush[1]), .bubble_count_o(bcnt[1])
  );

  function automatic bit reads_src(input logic [3:0] o, input int which);
    if (o == 4'b0001 || o == 4'b1010 || o == 4'b0100) return 1'b1;
    if (o == 4'b1001) return which == 1;
    return 1'b0;
  endfunction

  function automatic bit m_hazard(input int k);
    return (m_op[k] == 4'b1001) && m_ctrl[k][6] &&
           ((reads_src(op, 1) && rs1 == m_rd[k]) || (reads_src(op, 2) && rs2 == m_rd[k]));
  endfunction

  function automatic logic [1:0] m_sf(input int k);
    logic s;
    s = !br && (m_rem[k] > 0 || m_hazard(k));
    return {s, br};
  endfunction

  function automatic logic [RW-1:0] m_regs(input int k);
    return {m_ctrl[k], m_op[k], m_rd[k], m_d1[k], m_d2[k], m_imm[k]};
  endfunction

  function automatic logic [RW-1:0] dut_regs(input int k);
    return {ex_ctrl[k], ex_op[k], ex_rd[k], ex_d1[k], ex_d2[k], ex_imm[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ctrl[k] = '0; m_op[k] = '0; m_rd[k] = '0;
      m_d1[k] = '0; m_d2[k] = '0; m_imm[k] = '0;
      m_rem[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit haz, bub;
      int nrem;
      haz  = m_hazard(k);
      bub  = br || (m_rem[k] > 0) || haz;
      nrem = br ? 0 : (m_rem[k] > 0) ? m_rem[k] - 1 : haz ? lsc[k] - 1 : 0;
      if (bub) begin
        m_ctrl[k] = '0; m_op[k] = '0; m_rd[k] = '0;
        m_d1[k] = '0; m_d2[k] = '0; m_imm[k] = '0;
        if (m_cnt[k] < 65535) m_cnt[k]++;
      end else begin
        m_ctrl[k] = ctrl; m_op[k] = op; m_rd[k] = rd;
        m_d1[k] = d1; m_d2[k] = d2; m_imm[k] = imm;
      end
      m_rem[k] = nrem;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_id(input logic [6:0] c, input logic [3:0] o,
                        input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d);
    ctrl = c; op = o; rs1 = a; rs2 = b; rd = d;
    d1 = $urandom; d2 = $urandom; imm = $urandom;
  endtask

  task automatic do_reset();
    br = 1'b0;
    set_id(7'b0, 4'b0, '0, '0, '0);
    rst = 1'b1;
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    br  = 1'b0;
    set_id(7'b0, 4'b0, '0, '0, '0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (dut_regs(k) !== '0) $display("FAIL reset_regs[%0d] got %h exp 0", k, dut_regs(k));
      else pass_cnt++;
      total++;
      if (bcnt[k] !== 16'h0) $display("FAIL reset_bcnt[%0d] got %h exp 0", k, bcnt[k]);
      else pass_cnt++;
    end
    rst = 1'b0;
  endtask

  task automatic test_normal();
    do_reset();
    set_id(7'b1010001, 4'b0001, 4'd1, 4'd2, 4'd3);
    #1;
    total++;
    if ({stall[0], flush[0]} !== 2'b00) $display("FAIL normal_sf got %b exp 00", {stall[0], flush[0]});
    else pass_cnt++;
    tick();
    total++;
    if (ex_ctrl[0] !== 7'b1010001 || ex_rd[0] !== 4'd3)
      $display("FAIL normal_ex got ctrl=%b rd=%0d exp ctrl=1010001 rd=3", ex_ctrl[0], ex_rd[0]);
    else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (dut_regs(k) !== m_regs(k)) $display("FAIL normal_regs[%0d] got %h exp %h", k, dut_regs(k), m_regs(k));
      else pass_cnt++;
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(7'b1010000, 4'b1001, 4'd4, 4'd0, 4'd5);
    tick();
    set_id(7'b1010001, 4'b0001, 4'd5, 4'd2, 4'd6);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (stall[k] !== 1'b1 || flush[k] !== 1'b0)
        $display("FAIL lu_stall[%0d] got s=%b f=%b exp s=1 f=0", k, stall[k], flush[k]);
      else pass_cnt++;
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) begin
        total++;
        if (ex_ctrl[0] !== 7'b0) $display("FAIL lu_bubble got %b exp 0", ex_ctrl[0]);
        else pass_cnt++;
      end
      if (c == 1) begin
        total++;
        if (ex_op[0] !== 4'b0001 || ex_rd[0] !== 4'd6 || bcnt[0] !== 16'd1)
          $display("FAIL lu_a_release got op=%b rd=%0d bc=%0d exp op=0001 rd=6 bc=1", ex_op[0], ex_rd[0], bcnt[0]);
        else pass_cnt++;
      end
      for (int k = 0; k < 2; k++) begin
        total++;
        if (dut_regs(k) !== m_regs(k)) $display("FAIL lu_regs[%0d] c%0d got %h exp %h", k, c, dut_regs(k), m_regs(k));
        else pass_cnt++;
        total++;
        if ({stall[k], flush[k]} !== m_sf(k))
          $display("FAIL lu_sf[%0d] c%0d got %b exp %b", k, c, {stall[k], flush[k]}, m_sf(k));
        else pass_cnt++;
      end
    end
    total++;
    if (ex_op[1] !== 4'b0001 || bcnt[1] !== 16'd3)
      $display("FAIL lu_b_release got op=%b bc=%0d exp op=0001 bc=3", ex_op[1], bcnt[1]);
    else pass_cnt++;
  endtask

  task automatic test_no_false_hazard();
    do_reset();
    set_id(7'b1010000, 4'b1001, 4'd4, 4'd0, 4'd5);
    tick();
    set_id(7'b1010001, 4'b0001, 4'd1, 4'd2, 4'd6);
    #1;
    total++;
    if (stall[0] !== 1'b0 || stall[1] !== 1'b0) $display("FAIL nofalse_add got %b%b exp 00", stall[0], stall[1]);
    else pass_cnt++;
    do_reset();
    set_id(7'b1010000, 4'b1001, 4'd4, 4'd0, 4'd5);
    tick();
    set_id(7'b1010000, 4'b1001, 4'd4, 4'd5, 4'd7);
    #1;
    total++;
    if (stall[0] !== 1'b0 || stall[1] !== 1'b0) $display("FAIL nofalse_ldr got %b%b exp 00", stall[0], stall[1]);
    else pass_cnt++;
  endtask

  task automatic test_branch_in_stall();
    do_reset();
    set_id(7'b1010000, 4'b1001, 4'd4, 4'd0, 4'd5);
    tick();
    set_id(7'b1010001, 4'b0001, 4'd5, 4'd2, 4'd6);
    tick();
    br = 1'b1;
    #1;
    total++;
    if (flush[1] !== 1'b1 || stall[1] !== 1'b0)
      $display("FAIL br_stall_sf got s=%b f=%b exp s=0 f=1", stall[1], flush[1]);
    else pass_cnt++;
    tick();
    br = 1'b0;
    total++;
    if (bcnt[1] !== 16'd2) $display("FAIL br_stall_bcnt got %0d exp 2", bcnt[1]);
    else pass_cnt++;
    #1;
    total++;
    if (stall[1] !== 1'b0) $display("FAIL br_stall_run got stall=%b exp 0", stall[1]);
    else pass_cnt++;
    tick();
    total++;
    if (ex_op[1] !== 4'b0001 || ex_rd[1] !== 4'd6) $display("FAIL br_stall_load got op=%b rd=%0d exp op=0001 rd=6", ex_op[1], ex_rd[1]);
    else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (dut_regs(k) !== m_regs(k) || bcnt[k] !== 16'(m_cnt[k]))
        $display("FAIL br_model[%0d] got %h/%0d exp %h/%0d", k, dut_regs(k), bcnt[k], m_regs(k), m_cnt[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [3:0] ops [6];
    ops = '{4'b0000, 4'b0001, 4'b0100, 4'b1001, 4'b1010, 4'b1111};
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] o;
      logic [6:0] c;
      o = ops[$urandom_range(0, 5)];
      if (o == 4'b1111) o = 4'($urandom);
      c = 7'($urandom);
      if (o == 4'b1001 && $urandom_range(0, 3) != 0) c[6] = 1'b1;
      set_id(c, o, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      br = ($urandom_range(0, 9) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({stall[k], flush[k]} !== m_sf(k))
          $display("FAIL rand_sf[%0d] i%0d got %b exp %b", k, i, {stall[k], flush[k]}, m_sf(k));
        else pass_cnt++;
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (dut_regs(k) !== m_regs(k) || bcnt[k] !== 16'(m_cnt[k]))
          $display("FAIL rand_regs[%0d] i%0d got %h/%0d exp %h/%0d", k, i, dut_regs(k), bcnt[k], m_regs(k), m_cnt[k]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    br = 1'b0;
    set_id(7'b1010001, 4'b0001, 4'd9, 4'd10, 4'd11);
    d1 = 32'hDEAD_BEEF;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (dut_regs(k) !== '0 || bcnt[k] !== 16'h0)
        $display("FAIL reset_mid[%0d] got %h/%0d exp 0/0", k, dut_regs(k), bcnt[k]);
      else pass_cnt++;
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    br = 1'b1;
    repeat (65534) tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (bcnt[k] !== 16'hFFFE) $display("FAIL sat_pre[%0d] got %h exp fffe", k, bcnt[k]);
      else pass_cnt++;
    end
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (bcnt[k] !== 16'hFFFF || bcnt[k] !== 16'(m_cnt[k]))
        $display("FAIL sat_hold[%0d] got %h exp ffff", k, bcnt[k]);
      else pass_cnt++;
    end
    br = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_load_use();
    test_no_false_hazard();
    test_branch_in_stall();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
